// File: rtl/load_hazard_scoreboard.sv
// load_hazard_scoreboard -- load-use hazard unit tracking loads across a multi-cycle data memory.
// Rev 1.0
`default_nettype none

module load_hazard_scoreboard #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 3,
  parameter int ZERO_REG = 31,
  parameter int HAS_ZERO = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_rd,
  input  logic [REG_W-1:0] IFID_rn,
  input  logic [REG_W-1:0] IFID_rm,
  input  logic [REG_W-1:0] IFID_rd,
  input  logic             IFID_StoreEn,
  input  logic             mem_stall,
  output logic             PC_WriteEn,
  output logic             IFID_WriteEn,
  output logic             Stall_flush,
  output logic [CNT_W-1:0] stall_count
);

  localparam int NSLOT = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;

  logic [NSLOT-1:0] slot_hit_rn;
  logic [NSLOT-1:0] slot_hit_rm;
  logic [NSLOT-1:0] slot_hit_rd;
  logic             hit_rn;
  logic             hit_rm;
  logic             hit_rd;
  logic             hazard;

  function automatic logic is_zero(input logic [REG_W-1:0] r);
    return (HAS_ZERO != 0) && (r == REG_W'(ZERO_REG));
  endfunction

  generate
    if (LOAD_LAT > 1) begin : g_slots
      localparam logic [3:0] CNT_INIT = 4'(LOAD_LAT - 1);

      logic [REG_W-1:0] slot_reg [NSLOT];
      logic [3:0]       slot_cnt [NSLOT];
      logic [3:0]       cnt_nx   [NSLOT];
      logic [NSLOT-1:0] alloc_sel;
      logic             found;
      logic             do_alloc;

      always_comb begin
        slot_hit_rn = '0;
        slot_hit_rm = '0;
        slot_hit_rd = '0;
        alloc_sel   = '0;
        found       = 1'b0;
        do_alloc    = !mem_stall && IDEX_MemRead && !is_zero(IDEX_rd);
        for (int i = 0; i < NSLOT; i++) begin
          slot_hit_rn[i] = (slot_cnt[i] != 4'd0) && (slot_reg[i] == IFID_rn);
          slot_hit_rm[i] = (slot_cnt[i] != 4'd0) && (slot_reg[i] == IFID_rm);
          slot_hit_rd[i] = (slot_cnt[i] != 4'd0) && (slot_reg[i] == IFID_rd);
          cnt_nx[i]      = (slot_cnt[i] != 4'd0) ? slot_cnt[i] - 4'd1 : 4'd0;
        end
        // A slot draining to zero on this edge is already eligible for reuse.
        for (int i = 0; i < NSLOT; i++) begin
          if (!found && cnt_nx[i] == 4'd0) begin
            found        = 1'b1;
            alloc_sel[i] = 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < NSLOT; i++) begin
            slot_cnt[i] <= 4'd0;
            slot_reg[i] <= '0;
          end
        end else if (!mem_stall) begin
          for (int i = 0; i < NSLOT; i++) begin
            if (do_alloc && alloc_sel[i]) begin
              slot_reg[i] <= IDEX_rd;
              slot_cnt[i] <= CNT_INIT;
            end else begin
              slot_cnt[i] <= cnt_nx[i];
            end
          end
        end
      end
    end else begin : g_no_slots
      assign slot_hit_rn = '0;
      assign slot_hit_rm = '0;
      assign slot_hit_rd = '0;
    end
  endgenerate

  always_comb begin
    hit_rn = ((IDEX_MemRead && IFID_rn == IDEX_rd) || |slot_hit_rn) && !is_zero(IFID_rn);
    hit_rm = ((IDEX_MemRead && IFID_rm == IDEX_rd) || |slot_hit_rm) && !is_zero(IFID_rm);
    hit_rd = ((IDEX_MemRead && IFID_rd == IDEX_rd) || |slot_hit_rd) && !is_zero(IFID_rd);
    hazard = hit_rn || hit_rm || (IFID_StoreEn && hit_rd);
  end

  always_comb begin
    PC_WriteEn   = 1'b1;
    IFID_WriteEn = 1'b1;
    Stall_flush  = 1'b0;
    if (!rst_n) begin
      PC_WriteEn   = 1'b1;
      IFID_WriteEn = 1'b1;
    end else if (mem_stall) begin
      // Frozen pipe: hold everything, but do not bubble.
      PC_WriteEn   = 1'b0;
      IFID_WriteEn = 1'b0;
    end else if (hazard) begin
      PC_WriteEn   = 1'b0;
      IFID_WriteEn = 1'b0;
      Stall_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (Stall_flush && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_hazard_scoreboard.sv
// tb_load_hazard_scoreboard -- table-driven scoreboard bench for load_hazard_scoreboard.
// Rev 1.0
`default_nettype none

module tb_load_hazard_scoreboard;

  typedef struct {
    logic       rst_n;
    logic       mr;
    logic [4:0] idrd;
    logic [4:0] rn;
    logic [4:0] rm;
    logic [4:0] rd;
    logic       st;
    logic       ms;
    logic       pc;
    logic       fl;
  } vec_t;

  typedef struct {
    int          row;
    logic        pc;
    logic        fl;
    logic [15:0] cnt;
    logic [1:0]  cnt_sat;
  } exp_t;

  typedef struct {
    logic       mr;
    logic [4:0] idrd;
    logic [4:0] rn;
    logic       fl_nz;
    logic       fl_l1;
  } svec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, mr, st, ms;
  logic [4:0] idrd, rn, rm, rd;
  logic       pc_we, ifid_we, flush;
  logic [15:0] cnt;
  logic       sat_pc, sat_ifid, sat_fl;
  logic [1:0] sat_cnt;

  logic       s_rst_n, s_mr;
  logic [4:0] s_idrd, s_rn;
  logic [4:0] s_rm = 5'd2;
  logic [4:0] s_rd = 5'd0;
  logic       s_st = 1'b0;
  logic       s_ms = 1'b0;
  logic       nz_pc, nz_ifid, nz_fl;
  logic [15:0] nz_cnt;
  logic       l1_pc, l1_ifid, l1_fl;
  logic [15:0] l1_cnt;

  load_hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .IDEX_MemRead(mr), .IDEX_rd(idrd),
    .IFID_rn(rn), .IFID_rm(rm), .IFID_rd(rd), .IFID_StoreEn(st), .mem_stall(ms),
    .PC_WriteEn(pc_we), .IFID_WriteEn(ifid_we), .Stall_flush(flush), .stall_count(cnt)
  );

  load_hazard_scoreboard #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .IDEX_MemRead(mr), .IDEX_rd(idrd),
    .IFID_rn(rn), .IFID_rm(rm), .IFID_rd(rd), .IFID_StoreEn(st), .mem_stall(ms),
    .PC_WriteEn(sat_pc), .IFID_WriteEn(sat_ifid), .Stall_flush(sat_fl), .stall_count(sat_cnt)
  );

  load_hazard_scoreboard #(.HAS_ZERO(0)) dut_nz (
    .clk(clk), .rst_n(s_rst_n), .IDEX_MemRead(s_mr), .IDEX_rd(s_idrd),
    .IFID_rn(s_rn), .IFID_rm(s_rm), .IFID_rd(s_rd), .IFID_StoreEn(s_st), .mem_stall(s_ms),
    .PC_WriteEn(nz_pc), .IFID_WriteEn(nz_ifid), .Stall_flush(nz_fl), .stall_count(nz_cnt)
  );

  load_hazard_scoreboard #(.LOAD_LAT(1), .HAS_ZERO(0)) dut_l1 (
    .clk(clk), .rst_n(s_rst_n), .IDEX_MemRead(s_mr), .IDEX_rd(s_idrd),
    .IFID_rn(s_rn), .IFID_rm(s_rm), .IFID_rd(s_rd), .IFID_StoreEn(s_st), .mem_stall(s_ms),
    .PC_WriteEn(l1_pc), .IFID_WriteEn(l1_ifid), .Stall_flush(l1_fl), .stall_count(l1_cnt)
  );

  int total = 0;
  int bad   = 0;
  vec_t  vecs [30];
  svec_t svecs [4];
  exp_t  sb [$];

  function automatic vec_t mk(input logic r, input logic m, input logic [4:0] a,
                              input logic [4:0] b, input logic [4:0] c, input logic [4:0] d,
                              input logic s, input logic f, input logic p, input logic l);
    vec_t v;
    v.rst_n = r; v.mr = m; v.idrd = a; v.rn = b; v.rm = c; v.rd = d;
    v.st = s; v.ms = f; v.pc = p; v.fl = l;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s row %0d: got %0h want %0h", name, row, got, want);
    end
  endtask

  initial begin
    logic [15:0] m_cnt;
    logic [1:0]  m_sat;
    exp_t e;

    // rst, mr, idrd, rn, rm, rd, st, ms, exp_pc, exp_flush
    vecs[0]  = mk(0, 1,  5,  5, 5, 5, 1, 1, 1, 0);
    vecs[1]  = mk(0, 1,  3,  3, 2, 0, 0, 0, 1, 0);
    vecs[2]  = mk(1, 1,  5,  5, 2, 0, 0, 0, 0, 1);
    vecs[3]  = mk(1, 0,  0,  5, 2, 0, 0, 0, 0, 1);
    vecs[4]  = mk(1, 0,  0,  5, 2, 0, 0, 0, 0, 1);
    vecs[5]  = mk(1, 0,  0,  5, 2, 0, 0, 0, 1, 0);
    vecs[6]  = mk(1, 1, 31, 31, 2, 0, 0, 0, 1, 0);
    vecs[7]  = mk(1, 0,  0, 31, 2, 0, 0, 0, 1, 0);
    vecs[8]  = mk(1, 1,  5,  5, 2, 0, 0, 0, 0, 1);
    vecs[9]  = mk(1, 0,  0,  5, 2, 0, 0, 1, 0, 0);
    vecs[10] = mk(1, 0,  0,  5, 2, 0, 0, 0, 0, 1);
    vecs[11] = mk(1, 0,  0,  5, 2, 0, 0, 0, 0, 1);
    vecs[12] = mk(1, 0,  0,  5, 2, 0, 0, 0, 1, 0);
    vecs[13] = mk(1, 1,  7,  1, 2, 7, 0, 0, 1, 0);
    vecs[14] = mk(1, 0,  0,  1, 2, 7, 1, 0, 0, 1);
    vecs[15] = mk(1, 0,  0,  1, 2, 7, 0, 0, 1, 0);
    vecs[16] = mk(1, 1,  5,  1, 2, 0, 0, 0, 1, 0);
    vecs[17] = mk(1, 1,  6,  1, 6, 0, 0, 0, 0, 1);
    vecs[18] = mk(1, 0,  0,  1, 6, 0, 0, 0, 0, 1);
    vecs[19] = mk(1, 0,  0,  1, 6, 0, 0, 0, 0, 1);
    vecs[20] = mk(1, 0,  0,  1, 6, 0, 0, 0, 1, 0);
    vecs[21] = mk(1, 1,  5,  5, 2, 0, 0, 0, 0, 1);
    vecs[22] = mk(1, 1,  5,  5, 2, 0, 0, 0, 0, 1);
    vecs[23] = mk(1, 0,  0,  5, 2, 0, 0, 0, 0, 1);
    vecs[24] = mk(1, 0,  0,  5, 2, 0, 0, 0, 0, 1);
    vecs[25] = mk(1, 0,  0,  5, 2, 0, 0, 0, 1, 0);
    vecs[26] = mk(1, 1,  4,  1, 4, 0, 0, 0, 0, 1);
    vecs[27] = mk(1, 0,  0,  1, 4, 0, 0, 0, 0, 1);
    vecs[28] = mk(0, 0,  0,  1, 4, 0, 0, 0, 1, 0);
    vecs[29] = mk(1, 0,  0,  1, 4, 0, 0, 0, 1, 0);

    // zero register checked (HAS_ZERO=0): LOAD_LAT=3 gives 3 bubbles, LOAD_LAT=1 gives 1
    svecs[0] = '{1'b1, 5'd31, 5'd31, 1'b1, 1'b1};
    svecs[1] = '{1'b0, 5'd0,  5'd31, 1'b1, 1'b0};
    svecs[2] = '{1'b0, 5'd0,  5'd31, 1'b1, 1'b0};
    svecs[3] = '{1'b0, 5'd0,  5'd31, 1'b0, 1'b0};

    rst_n = 1'b0; mr = 1'b0; idrd = '0; rn = '0; rm = '0; rd = '0; st = 1'b0; ms = 1'b0;
    s_rst_n = 1'b0; s_mr = 1'b0; s_idrd = '0; s_rn = '0;
    m_cnt = '0;
    m_sat = '0;
    @(posedge clk);

    for (int i = 0; i < 30; i++) begin
      #1;
      rst_n = vecs[i].rst_n; mr = vecs[i].mr; idrd = vecs[i].idrd;
      rn = vecs[i].rn; rm = vecs[i].rm; rd = vecs[i].rd; st = vecs[i].st; ms = vecs[i].ms;
      e.row = i; e.pc = vecs[i].pc; e.fl = vecs[i].fl; e.cnt = m_cnt; e.cnt_sat = m_sat;
      sb.push_back(e);
      if (!vecs[i].rst_n) begin
        m_cnt = '0;
        m_sat = '0;
      end else if (vecs[i].fl) begin
        if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
        if (m_sat != 2'd3) m_sat = m_sat + 2'd1;
      end
      @(negedge clk);
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty row %0d: got 0 entries want 1", i);
      end else begin
        e = sb.pop_front();
        chk("pc_we",       e.row, 32'(pc_we),   32'(e.pc));
        chk("ifid_we",     e.row, 32'(ifid_we), 32'(e.pc));
        chk("stall_flush", e.row, 32'(flush),   32'(e.fl));
        chk("stall_count", e.row, 32'(cnt),     32'(e.cnt));
        chk("sat_count",   e.row, 32'(sat_cnt), 32'(e.cnt_sat));
      end
      @(posedge clk);
    end

    for (int i = 0; i < 4; i++) begin
      #1;
      s_rst_n = 1'b1; s_mr = svecs[i].mr; s_idrd = svecs[i].idrd; s_rn = svecs[i].rn;
      @(negedge clk);
      chk("nz_flush", 100 + i, 32'(nz_fl), 32'(svecs[i].fl_nz));
      chk("nz_pc_we", 100 + i, 32'(nz_pc), 32'(!svecs[i].fl_nz));
      chk("l1_flush", 100 + i, 32'(l1_fl), 32'(svecs[i].fl_l1));
      chk("l1_ifid",  100 + i, 32'(l1_ifid), 32'(!svecs[i].fl_l1));
      @(posedge clk);
    end
    #1;
    @(negedge clk);
    chk("nz_count", 104, 32'(nz_cnt), 32'd3);
    chk("l1_count", 104, 32'(l1_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
